// File: rtl/factorial_host_master.sv
// Bus initiator that runs one complete factorial operation on the controller's
// register port per accepted request, by polling or by waiting on the interrupt.
module factorial_host_master #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          POLL_GAP  = 4,
  parameter int          MAX_WAIT  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [63:0] req_operand,
  input  logic        use_intr,
  input  logic        intr,
  output logic        m_sel,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic [63:0] m_din,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] result_h,
  output logic [63:0] result_l
);

  localparam logic [15:0] OFF_START   = 16'h0000;
  localparam logic [15:0] OFF_CLEAR   = 16'h0008;
  localparam logic [15:0] OFF_DONE    = 16'h0010;
  localparam logic [15:0] OFF_INTR_EN = 16'h0018;
  localparam logic [15:0] OFF_OPERAND = 16'h0020;
  localparam logic [15:0] OFF_RES_H   = 16'h0028;
  localparam logic [15:0] OFF_RES_L   = 16'h0030;
  localparam logic [15:0] WAIT_LIMIT  = 16'(MAX_WAIT);
  localparam logic [7:0]  GAP_LAST    = 8'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_INTR, S_WR_OPND, S_WR_START, S_RD_DONE, S_RD_DONE_W, S_GAP,
    S_WAIT_INTR, S_RD_RH, S_RD_RH_W, S_RD_RL, S_RD_RL_W, S_WR_CLR, S_CLR_W, S_FINISH
  } state_t;

  state_t      r_state, w_next;
  logic [63:0] r_operand;
  logic        r_use_intr;
  logic [15:0] r_wait_cnt;
  logic [7:0]  r_gap_cnt;
  logic        r_m_sel, r_m_wr, r_busy, r_done, r_error;
  logic [15:0] r_m_addr;
  logic [63:0] r_m_dout, r_result_h, r_result_l;

  logic        w_wait_state, w_expired, w_timeout, w_use_intr, w_accept;
  logic [15:0] w_wait_inc;
  logic        w_sel, w_wr;
  logic [15:0] w_addr;
  logic [63:0] w_dout;

  assign w_wait_state = r_state inside {S_RD_DONE, S_RD_DONE_W, S_GAP, S_WAIT_INTR};
  assign w_wait_inc   = r_wait_cnt + 16'd1;
  assign w_expired    = (w_wait_inc == WAIT_LIMIT);
  assign w_timeout    = w_wait_state && (w_next == S_WR_CLR);
  assign w_accept     = (r_state == S_IDLE) && req;
  // The intrEn write is decoded on the accepting edge, before r_use_intr is loaded.
  assign w_use_intr   = (r_state == S_IDLE) ? use_intr : r_use_intr;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (req) w_next = S_WR_INTR;
      S_WR_INTR:   w_next = S_WR_OPND;
      S_WR_OPND:   w_next = S_WR_START;
      S_WR_START:  w_next = r_use_intr ? S_WAIT_INTR : S_RD_DONE;
      S_RD_DONE:   w_next = w_expired ? S_WR_CLR : S_RD_DONE_W;
      S_RD_DONE_W: begin
        if (m_din[1:0] != 2'b00) w_next = S_RD_RH;
        else if (w_expired)      w_next = S_WR_CLR;
        else if (POLL_GAP == 0)  w_next = S_RD_DONE;
        else                     w_next = S_GAP;
      end
      S_GAP: begin
        if (w_expired)                  w_next = S_WR_CLR;
        else if (r_gap_cnt == GAP_LAST) w_next = S_RD_DONE;
      end
      S_WAIT_INTR: begin
        if (intr)           w_next = S_RD_RH;
        else if (w_expired) w_next = S_WR_CLR;
      end
      S_RD_RH:     w_next = S_RD_RH_W;
      S_RD_RH_W:   w_next = S_RD_RL;
      S_RD_RL:     w_next = S_RD_RL_W;
      S_RD_RL_W:   w_next = S_WR_CLR;
      S_WR_CLR:    w_next = S_CLR_W;
      S_CLR_W:     w_next = S_FINISH;
      S_FINISH:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Bus fields are decoded from the next state so the registered outputs line up with that state's cycle.
  always_comb begin
    w_sel  = 1'b0;
    w_wr   = 1'b0;
    w_addr = '0;
    w_dout = '0;
    case (w_next)
      S_WR_INTR:  begin w_sel = 1'b1; w_wr = 1'b1; w_addr = BASE_ADDR + OFF_INTR_EN; w_dout = {63'h0, w_use_intr}; end
      S_WR_OPND:  begin w_sel = 1'b1; w_wr = 1'b1; w_addr = BASE_ADDR + OFF_OPERAND; w_dout = r_operand; end
      S_WR_START: begin w_sel = 1'b1; w_wr = 1'b1; w_addr = BASE_ADDR + OFF_START;   w_dout = 64'h1; end
      S_WR_CLR:   begin w_sel = 1'b1; w_wr = 1'b1; w_addr = BASE_ADDR + OFF_CLEAR;   w_dout = 64'h1; end
      S_RD_DONE:  begin w_sel = 1'b1; w_addr = BASE_ADDR + OFF_DONE;  end
      S_RD_RH:    begin w_sel = 1'b1; w_addr = BASE_ADDR + OFF_RES_H; end
      S_RD_RL:    begin w_sel = 1'b1; w_addr = BASE_ADDR + OFF_RES_L; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_operand  <= '0;
      r_use_intr <= 1'b0;
      r_wait_cnt <= '0;
      r_gap_cnt  <= '0;
      r_m_sel    <= 1'b0;
      r_m_wr     <= 1'b0;
      r_m_addr   <= '0;
      r_m_dout   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_result_h <= '0;
      r_result_l <= '0;
    end else begin
      r_state  <= w_next;
      r_m_sel  <= w_sel;
      r_m_wr   <= w_wr;
      r_m_addr <= w_addr;
      r_m_dout <= w_dout;
      r_busy   <= (w_next != S_IDLE);
      r_done   <= (w_next == S_FINISH);
      if (w_accept) begin
        r_operand  <= req_operand;
        r_use_intr <= use_intr;
        r_error    <= 1'b0;
        r_result_h <= '0;
        r_result_l <= '0;
      end
      if (w_timeout) r_error <= 1'b1;
      if (r_state == S_RD_RH_W) r_result_h <= m_din;
      if (r_state == S_RD_RL_W) r_result_l <= m_din;
      if (r_state == S_WR_START) r_wait_cnt <= '0;
      else if (w_wait_state)     r_wait_cnt <= w_wait_inc;
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 8'd1 : 8'd0;
    end
  end

  assign m_sel    = r_m_sel;
  assign m_wr     = r_m_wr;
  assign m_addr   = r_m_addr;
  assign m_dout   = r_m_dout;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign result_h = r_result_h;
  assign result_l = r_result_l;

endmodule

// File: tb/tb_factorial_host_master.sv
// Bench for factorial_host_master: two instances (base 0x0000 / MAX_WAIT 1024 and
// base 0x0100 / MAX_WAIT 16) against a behavioural register slave and a transaction-level model.
module tb_factorial_host_master;

  localparam logic [15:0] BASE0 = 16'h0000;
  localparam logic [15:0] BASE1 = 16'h0100;
  localparam int          MW0   = 1024;
  localparam int          MW1   = 16;
  localparam int          GAP   = 4;
  localparam int          LOGSZ = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req [2];
  logic [63:0] req_operand [2];
  logic        use_intr [2];
  logic        intr [2];
  logic        m_sel [2];
  logic        m_wr [2];
  logic [15:0] m_addr [2];
  logic [63:0] m_dout [2];
  logic [63:0] m_din [2];
  logic        busy [2];
  logic        done [2];
  logic        error [2];
  logic [63:0] result_h [2];
  logic [63:0] result_l [2];

  factorial_host_master #(.BASE_ADDR(BASE0), .POLL_GAP(GAP), .MAX_WAIT(MW0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req(req[0]), .req_operand(req_operand[0]),
    .use_intr(use_intr[0]), .intr(intr[0]), .m_sel(m_sel[0]), .m_wr(m_wr[0]),
    .m_addr(m_addr[0]), .m_dout(m_dout[0]), .m_din(m_din[0]), .busy(busy[0]),
    .done(done[0]), .error(error[0]), .result_h(result_h[0]), .result_l(result_l[0]));

  factorial_host_master #(.BASE_ADDR(BASE1), .POLL_GAP(GAP), .MAX_WAIT(MW1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req[1]), .req_operand(req_operand[1]),
    .use_intr(use_intr[1]), .intr(intr[1]), .m_sel(m_sel[1]), .m_wr(m_wr[1]),
    .m_addr(m_addr[1]), .m_dout(m_dout[1]), .m_din(m_din[1]), .busy(busy[1]),
    .done(done[1]), .error(error[1]), .result_h(result_h[1]), .result_l(result_l[1]));

  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] p;
    p = 128'd1;
    for (int i = 2; i <= 40; i++) if (64'(i) <= n) p = p * 128'(i);
    return p;
  endfunction

  function automatic logic [15:0] addr_off(input int d, input logic [15:0] a);
    return a - ((d == 0) ? BASE0 : BASE1);
  endfunction

  // ---------------- slave model and bus log ----------------
  int           cyc = 0;
  int           viol [2] = '{0, 0};
  int           cfg_npoll [2] = '{0, 0};
  int           cfg_idel [2] = '{0, 0};
  logic [63:0]  s_operand [2];
  logic [127:0] s_res [2];
  logic         s_started [2];
  int           s_polls [2];
  int           s_icnt [2];
  logic [80:0]  log_t [2][LOGSZ];
  int           log_c [2][LOGSZ];
  int           log_n [2] = '{0, 0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if ((!m_sel[d] && (m_wr[d] || m_addr[d] != 16'h0 || m_dout[d] != 64'h0)) ||
          (m_sel[d] && !m_wr[d] && m_dout[d] != 64'h0) || (done[d] && !busy[d]))
        viol[d] <= viol[d] + 1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        m_din[d]     <= '0;
        intr[d]      <= 1'b0;
        s_started[d] <= 1'b0;
        s_polls[d]   <= 0;
        s_icnt[d]    <= 0;
        s_operand[d] <= '0;
        s_res[d]     <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_din[d] <= {$urandom, $urandom};
        if (s_started[d]) begin
          s_icnt[d] <= s_icnt[d] + 1;
          intr[d]   <= (cfg_idel[d] != 0) && (s_icnt[d] + 1 >= cfg_idel[d]);
        end
        if (m_sel[d]) begin
          if (log_n[d] < LOGSZ) begin
            log_t[d][log_n[d]] <= {m_wr[d], m_addr[d], m_dout[d]};
            log_c[d][log_n[d]] <= cyc;
          end
          log_n[d] <= log_n[d] + 1;
          if (m_wr[d]) begin
            case (addr_off(d, m_addr[d]))
              16'h00: if (m_dout[d][0]) begin
                s_started[d] <= 1'b1;
                s_polls[d]   <= 0;
                s_icnt[d]    <= 1;
                intr[d]      <= (cfg_idel[d] == 1);
                s_res[d]     <= fact(s_operand[d]);
              end
              16'h08: if (m_dout[d][0]) begin
                s_started[d] <= 1'b0;
                intr[d]      <= 1'b0;
              end
              16'h20: s_operand[d] <= m_dout[d];
              default: ;
            endcase
          end else begin
            case (addr_off(d, m_addr[d]))
              16'h10: begin
                s_polls[d] <= s_polls[d] + 1;
                if (cfg_npoll[d] != 0 && s_polls[d] + 1 >= cfg_npoll[d])
                  m_din[d] <= ({$urandom, $urandom} & ~64'h3) | 64'($urandom_range(1, 3));
                else
                  m_din[d] <= {$urandom, $urandom} & ~64'h3;
              end
              16'h28: m_din[d] <= s_res[d][127:64];
              16'h30: m_din[d] <= s_res[d][63:0];
              default: ;
            endcase
          end
        end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [80:0] t;
    int          c;
  } ev_t;

  ev_t         exp_q[$];
  logic        exp_err;
  logic [63:0] exp_rh, exp_rl;
  int          exp_done;
  int          last_c0, last_done;

  function automatic void push(input logic wr, input logic [15:0] a, input logic [63:0] dat, input int c);
    ev_t e;
    e.t = {wr, a, dat};
    e.c = c;
    exp_q.push_back(e);
  endfunction

  // Expected bus transactions (with their cycle numbers) for one request accepted in cycle c0.
  function automatic void build(input int d, input logic ui, input logic [63:0] opnd,
                                input int npoll, input int idel, input int c0);
    logic [15:0]  b;
    logic [127:0] f;
    int           mw, s, rr, clr, t;
    bit           ok;
    b  = (d == 0) ? BASE0 : BASE1;
    mw = (d == 0) ? MW0 : MW1;
    exp_q.delete();
    push(1'b1, b + 16'h18, {63'h0, ui}, c0 + 1);
    push(1'b1, b + 16'h20, opnd, c0 + 2);
    push(1'b1, b + 16'h00, 64'h1, c0 + 3);
    s  = c0 + 3;
    ok = 1'b0;
    rr = 0;
    if (!ui) begin
      for (int k = 1; k <= 1000; k++) begin
        t = 1 + (k - 1) * (2 + GAP);
        if (t > mw) break;
        push(1'b0, b + 16'h10, 64'h0, s + t);
        if (npoll != 0 && k >= npoll) begin
          if (t + 1 <= mw) begin
            ok = 1'b1;
            rr = s + t + 2;
          end
          break;
        end
      end
    end else if (idel >= 1 && idel <= mw) begin
      ok = 1'b1;
      rr = s + idel + 1;
    end
    f = fact(opnd);
    if (ok) begin
      push(1'b0, b + 16'h28, 64'h0, rr);
      push(1'b0, b + 16'h30, 64'h0, rr + 2);
      clr = rr + 4;
    end else begin
      clr = s + mw + 1;
    end
    push(1'b1, b + 16'h08, 64'h1, clr);
    exp_done = clr + 2;
    exp_err  = !ok;
    exp_rh   = ok ? f[127:64] : 64'h0;
    exp_rl   = ok ? f[63:0]   : 64'h0;
  endfunction

  task automatic compare_log(input int d, input int base);
    check("txn_count", 128'(log_n[d] - base), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < log_n[d] && base + i < LOGSZ) begin
        check("txn", 128'(log_t[d][base + i]), 128'(exp_q[i].t));
        check("txn_cycle", 128'(log_c[d][base + i]), 128'(exp_q[i].c));
      end
    end
  endtask

  task automatic run_op(input int d, input logic ui, input logic [63:0] opnd,
                        input int npoll, input int idel, input bit pulses);
    int c0, base;
    bit seen;
    cfg_npoll[d] = npoll;
    cfg_idel[d]  = idel;
    @(negedge clk);
    base           = log_n[d];
    c0             = cyc;
    req[d]         = 1'b1;
    req_operand[d] = opnd;
    use_intr[d]    = ui;
    build(d, ui, opnd, npoll, idel, c0);
    @(negedge clk);
    req[d]         = 1'b0;
    req_operand[d] = {$urandom, $urandom};
    use_intr[d]    = ~ui;
    check("busy_rise", 128'(busy[d]), 128'(1));
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (done[d]) begin
        seen      = 1'b1;
        last_done = cyc;
        req[d]    = 1'b0;
      end else begin
        if (pulses) req[d] = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    last_c0 = c0;
    check("done_seen", 128'(seen), 128'(1));
    if (seen) begin
      check("done_cycle", 128'(last_done), 128'(exp_done));
      check("busy_at_done", 128'(busy[d]), 128'(1));
      check("error", 128'(error[d]), 128'(exp_err));
      check("result_h", 128'(result_h[d]), 128'(exp_rh));
      check("result_l", 128'(result_l[d]), 128'(exp_rl));
    end
    @(negedge clk);
    check("done_pulse", 128'(done[d]), 128'(0));
    check("busy_fall", 128'(busy[d]), 128'(0));
    repeat (4) @(negedge clk);
    check("hold_result_l", 128'(result_l[d]), 128'(exp_rl));
    compare_log(d, base);
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, "_sel"},  128'(m_sel[d]),    128'(0));
    check({tag, "_wr"},   128'(m_wr[d]),     128'(0));
    check({tag, "_addr"}, 128'(m_addr[d]),   128'(0));
    check({tag, "_dout"}, 128'(m_dout[d]),   128'(0));
    check({tag, "_busy"}, 128'(busy[d]),     128'(0));
    check({tag, "_done"}, 128'(done[d]),     128'(0));
    check({tag, "_err"},  128'(error[d]),    128'(0));
    check({tag, "_rh"},   128'(result_h[d]), 128'(0));
    check({tag, "_rl"},   128'(result_l[d]), 128'(0));
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int c0, base, ndone, nstart;
    int tdone [2];
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d]         = 1'b0;
      req_operand[d] = '0;
      use_intr[d]    = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Poll mode, operand 5, done on the third poll.
    run_op(0, 1'b0, 64'd5, 3, 0, 1'b0);
    check("tp_poll_rl", 128'(result_l[0]), 128'(64'd120));
    check("tp_poll_rh", 128'(result_h[0]), 128'(0));

    // Interrupt mode, operand 20, intr 30 cycles after start.
    run_op(0, 1'b1, 64'd20, 0, 30, 1'b0);
    check("tp_intr_rl", 128'(result_l[0]), 128'(64'h21C3677C82B40000));

    // Base 0x0100: done on the first poll gives done in cycle 12.
    run_op(1, 1'b0, 64'd6, 1, 0, 1'b0);
    check("latency_done", 128'(last_done - last_c0), 128'(12));

    // Timeout in poll mode, done never reported.
    run_op(1, 1'b0, 64'd9, 0, 0, 1'b0);
    check("timeout_err", 128'(error[1]), 128'(1));

    // Interrupt on the very cycle the wait counter reaches MAX_WAIT: success.
    run_op(1, 1'b1, 64'd4, 0, 16, 1'b0);
    check("edge_ok_rl", 128'(result_l[1]), 128'(64'd24));

    // req pulsed while busy: exactly one operation.
    run_op(0, 1'b0, 64'd10, 4, 0, 1'b1);

    // req held high across two IDLE acceptances.
    cfg_npoll[0] = 1;
    @(negedge clk);
    base           = log_n[0];
    c0             = cyc;
    req[0]         = 1'b1;
    req_operand[0] = 64'd7;
    use_intr[0]    = 1'b0;
    ndone          = 0;
    tdone          = '{0, 0};
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cyc == c0 + 14) req[0] = 1'b0;
      if (done[0]) begin
        if (ndone < 2) tdone[ndone] = cyc;
        ndone++;
      end
    end
    req[0] = 1'b0;
    nstart = 0;
    for (int i = base; i < log_n[0] && i < LOGSZ; i++)
      if (log_t[0][i][80:64] == {1'b1, BASE0}) nstart++;
    check("held_done_count", 128'(ndone), 128'(2));
    check("held_done1", 128'(tdone[0]), 128'(c0 + 12));
    check("held_done2", 128'(tdone[1]), 128'(c0 + 25));
    check("held_starts", 128'(nstart), 128'(2));
    check("held_rl", 128'(result_l[0]), 128'(64'd5040));

    // Randomized operations on both instances.
    for (int n = 0; n < 6; n++)
      run_op(0, 1'($urandom_range(0, 1)), 64'($urandom_range(0, 25)),
             $urandom_range(1, 5), $urandom_range(1, 60), 1'b0);
    for (int n = 0; n < 5; n++)
      run_op(1, 1'($urandom_range(0, 1)), 64'($urandom_range(0, 25)),
             $urandom_range(1, 4), $urandom_range(1, 20), 1'($urandom_range(0, 1)));

    // Interrupt one cycle too late: timeout, leaves error set on instance 1.
    run_op(1, 1'b1, 64'd3, 0, 17, 1'b0);
    check("late_intr_err", 128'(error[1]), 128'(1));

    // Asynchronous reset in the middle of RD_RH_W.
    cfg_npoll[0] = 1;
    @(negedge clk);
    c0             = cyc;
    req[0]         = 1'b1;
    req_operand[0] = 64'd8;
    use_intr[0]    = 1'b0;
    @(negedge clk);
    req[0] = 1'b0;
    for (int k = 0; k < 20 && cyc != c0 + 7; k++) @(negedge clk);
    check("rst_point", 128'(cyc), 128'(c0 + 7));
    check("rst_busy_before", 128'(busy[0]), 128'(1));
    reset_n = 1'b0;
    #1;
    check_zero(0, "midrst0");
    check_zero(1, "midrst1");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_sel", 128'(m_sel[0]), 128'(0));
    check("post_rst_idle_busy", 128'(busy[0]), 128'(0));
    run_op(0, 1'b0, 64'd9, 2, 0, 1'b0);
    run_op(0, 1'b1, 64'd12, 0, 5, 1'b0);

    check("bus_rules0", 128'(viol[0]), 128'(0));
    check("bus_rules1", 128'(viol[1]), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
